// File: rtl/bcd2count_if.sv
// Request/response bundle for bcd2count: start strobe, nine BCD digits, status and result.
interface bcd2count_if #(
  parameter int unsigned BITS = 29
);
  logic            start;
  logic [3:0]      bcd_h_1;
  logic [3:0]      bcd_h_0;
  logic [3:0]      bcd_min_1;
  logic [3:0]      bcd_min_0;
  logic [3:0]      bcd_s_1;
  logic [3:0]      bcd_s_0;
  logic [3:0]      bcd_ms_2;
  logic [3:0]      bcd_ms_1;
  logic [3:0]      bcd_ms_0;
  logic            busy;
  logic            done;
  logic            error;
  logic [BITS-1:0] count;

  modport master (
    output start, bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0,
           bcd_ms_2, bcd_ms_1, bcd_ms_0,
    input  busy, done, error, count
  );

  modport slave (
    input  start, bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0,
           bcd_ms_2, bcd_ms_1, bcd_ms_0,
    output busy, done, error, count
  );
endinterface

// File: rtl/bcd2count.sv
// Sequential hh:mm:ss.mmm BCD to binary millisecond converter, one digit per falling edge.
// Define BCD2COUNT_HOUR24_EN to also reject hours above 23.
module bcd2count #(
  parameter int unsigned BITS = 29
) (
  input logic       NEclk,
  input logic       reset,
  bcd2count_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCheck, StConv} state_e;

  state_e          state_q, state_d;
  logic [35:0]     sreg_q, sreg_d;
  logic [3:0]      idx_q, idx_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic [BITS-1:0] count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic [3:0]      dig;
  logic [BITS-1:0] dig_ext;
  logic [BITS-1:0] acc_mac;
  logic            bad;

  assign dig     = sreg_q[35:32];
  assign dig_ext = {{(BITS-4){1'b0}}, dig};

  // Radix of the digit being folded in: hours tens starts the sum, tens of min/sec are base 6.
  always_comb begin
    case (idx_q)
      4'd0:       acc_mac = dig_ext;
      4'd2, 4'd4: acc_mac = (acc_q << 2) + (acc_q << 1) + dig_ext;
      default:    acc_mac = (acc_q << 3) + (acc_q << 1) + dig_ext;
    endcase
  end

  // Shift register layout: h1 at [35:32] down to ms0 at [3:0].
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (sreg_q[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    if (sreg_q[27:24] > 4'd5) bad = 1'b1;
    if (sreg_q[19:16] > 4'd5) bad = 1'b1;
`ifdef BCD2COUNT_HOUR24_EN
    if (sreg_q[35:32] > 4'd2) bad = 1'b1;
    if (sreg_q[35:32] == 4'd2 && sreg_q[31:28] > 4'd3) bad = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sreg_d  = {bus.bcd_h_1, bus.bcd_h_0, bus.bcd_min_1, bus.bcd_min_0,
                     bus.bcd_s_1, bus.bcd_s_0, bus.bcd_ms_2, bus.bcd_ms_1, bus.bcd_ms_0};
          acc_d   = '0;
          idx_d   = 4'd0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (bad) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d  = acc_mac;
        sreg_d = {sreg_q[31:0], 4'h0};
        idx_d  = idx_q + 4'd1;
        if (idx_q == 4'd8) begin
          count_d = acc_mac;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge NEclk) begin
    if (reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.error = error_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_bcd2count.sv
// Self-checking bench for bcd2count against an arithmetic hh:mm:ss.mmm reference model.
module tb_bcd2count;
  localparam int unsigned BITS = 29;

  logic NEclk = 1'b1;
  logic reset = 1'b1;

  bcd2count_if #(.BITS(BITS)) bif ();
  bcd2count #(.BITS(BITS)) dut (.NEclk(NEclk), .reset(reset), .bus(bif));

  always #5 NEclk = ~NEclk;

  int checks = 0;
  int errors = 0;
  logic [BITS-1:0] exp_count = '0;

  function automatic bit ref_valid(input logic [35:0] d);
    for (int i = 0; i < 9; i++) if (int'(d[i*4 +: 4]) > 9) return 1'b0;
    if (int'(d[27:24]) > 5 || int'(d[19:16]) > 5) return 1'b0;
`ifdef BCD2COUNT_HOUR24_EN
    if (int'(d[35:32]) * 10 + int'(d[31:28]) > 23) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic int unsigned ref_ms(input logic [35:0] d);
    int unsigned h, m, s, ms;
    h  = int'(d[35:32]) * 10 + int'(d[31:28]);
    m  = int'(d[27:24]) * 10 + int'(d[23:20]);
    s  = int'(d[19:16]) * 10 + int'(d[15:12]);
    ms = int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    return h * 3600000 + m * 60000 + s * 1000 + ms;
  endfunction

  // Drives one request; returns at the first posedge after the accepting falling edge.
  task automatic launch(input logic [35:0] d);
    @(posedge NEclk);
    {bif.bcd_h_1, bif.bcd_h_0, bif.bcd_min_1, bif.bcd_min_0, bif.bcd_s_1, bif.bcd_s_0,
     bif.bcd_ms_2, bif.bcd_ms_1, bif.bcd_ms_0} = d;
    bif.start = 1'b1;
    @(posedge NEclk);
    bif.start = 1'b0;
    {bif.bcd_h_1, bif.bcd_h_0, bif.bcd_min_1, bif.bcd_min_0, bif.bcd_s_1, bif.bcd_s_0,
     bif.bcd_ms_2, bif.bcd_ms_1, bif.bcd_ms_0} = {$urandom, 4'h0};
  endtask

  // lat = falling edges from accept to done (-1 on timeout); busy_n = cycles busy seen before.
  task automatic wait_done(output int lat, output int busy_n);
    lat = -1;
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(posedge NEclk);
      if (bif.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bif.busy === 1'b1) busy_n++;
    end
  endtask

  task automatic test_reset();
    @(posedge NEclk);
    reset = 1'b1;
    repeat (2) @(posedge NEclk);
    reset = 1'b0;
    exp_count = '0;
    checks++; if (bif.count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", bif.count); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bif.busy); end
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bif.done); end
    checks++; if (bif.error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bif.error); end
  endtask

  task automatic test_directed();
    logic [35:0] vec [7];
    bit ok;
    int lat, busy_n;
    vec = '{36'h010203456, 36'h995959999, 36'h000000000, 36'h006000000,
            36'h123456789, 36'h00000000A, 36'h240000000};
    for (int i = 0; i < 7; i++) begin
      ok = ref_valid(vec[i]);
      if (ok) exp_count = ref_ms(vec[i]);
      launch(vec[i]);
      wait_done(lat, busy_n);
      checks++;
      if (lat !== (ok ? 10 : 1)) begin
        errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, ok ? 10 : 1);
      end
      checks++;
      if (busy_n !== (ok ? 10 : 1) || bif.busy !== 1'b0) begin
        errors++; $display("FAIL dir%0d_busy got %0d/%b want %0d/0", i, busy_n, bif.busy, ok ? 10 : 1);
      end
      checks++;
      if (bif.error !== !ok) begin
        errors++; $display("FAIL dir%0d_error got %b want %b", i, bif.error, !ok);
      end
      checks++;
      if (bif.count !== exp_count) begin
        errors++; $display("FAIL dir%0d_count got %0d want %0d", i, bif.count, exp_count);
      end
      @(posedge NEclk);
      checks++;
      if (bif.done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b want 0", i, bif.done); end
    end
  endtask

  task automatic test_random();
    logic [35:0] d;
    bit ok;
    int lat, busy_n;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 9; i++) d[i*4 +: 4] = 4'($urandom_range(0, 9));
      d[27:24] = 4'($urandom_range(0, 5));
      d[19:16] = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) d[$urandom_range(0, 8)*4 +: 4] = 4'($urandom_range(0, 15));
      ok = ref_valid(d);
      if (ok) exp_count = ref_ms(d);
      launch(d);
      wait_done(lat, busy_n);
      checks++;
      if (lat !== (ok ? 10 : 1) || bif.error !== !ok || bif.count !== exp_count) begin
        errors++;
        $display("FAIL rand%0d d=%h got lat %0d err %b count %0d want lat %0d err %b count %0d",
                 n, d, lat, bif.error, bif.count, ok ? 10 : 1, !ok, exp_count);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [35:0] d = 36'h123456789;
    int dones = 0;
    int first = -1;
    exp_count = ref_ms(d);
    launch(d);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(posedge NEclk);
      bif.start = (k == 3);
      if (bif.done === 1'b1) begin
        dones++;
        if (first < 0) first = k;
      end
    end
    bif.start = 1'b0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_dones got %0d want 1", dones); end
    checks++; if (first !== 10) begin errors++; $display("FAIL ignore_latency got %0d want 10", first); end
    checks++;
    if (bif.count !== exp_count) begin
      errors++; $display("FAIL ignore_count got %0d want %0d", bif.count, exp_count);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    launch(36'h010203456);
    repeat (4) @(posedge NEclk);
    reset = 1'b1;
    @(posedge NEclk);
    reset = 1'b0;
    exp_count = '0;
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bif.busy); end
    checks++;
    if (bif.count !== exp_count) begin
      errors++; $display("FAIL abort_count got %0d want 0", bif.count);
    end
    for (int k = 0; k < 12; k++) begin
      if (bif.done === 1'b1) dones++;
      @(posedge NEclk);
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", dones); end
  endtask

  task automatic test_back_to_back();
    logic [35:0] d1 = 36'h995959999;
    logic [35:0] d2 = 36'h000100001;
    int lat, busy_n;
    launch(d1);
    wait_done(lat, busy_n);
    {bif.bcd_h_1, bif.bcd_h_0, bif.bcd_min_1, bif.bcd_min_0, bif.bcd_s_1, bif.bcd_s_0,
     bif.bcd_ms_2, bif.bcd_ms_1, bif.bcd_ms_0} = d2;
    bif.start = 1'b1;
    @(posedge NEclk);
    bif.start = 1'b0;
    checks++;
    if (bif.busy !== 1'b1 || bif.done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got busy %b done %b want 1 0", bif.busy, bif.done);
    end
    exp_count = ref_ms(d2);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 10 || bif.count !== exp_count) begin
      errors++; $display("FAIL b2b_result got lat %0d count %0d want 10 %0d", lat, bif.count, exp_count);
    end
  endtask

  initial begin
    bif.start = 1'b0;
    {bif.bcd_h_1, bif.bcd_h_0, bif.bcd_min_1, bif.bcd_min_0, bif.bcd_s_1, bif.bcd_s_0,
     bif.bcd_ms_2, bif.bcd_ms_1, bif.bcd_ms_0} = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
